nvram_ioctl_bridge: RTL and testbench

- Serves the HPS ioctl channel in both directions for the high-score/NVRAM region of the game work RAM.
- On upload (save), reads RAM and returns bytes to hps_io on ioctl_din, stalling with ioctl_wait.
- On download of the NVRAM index (restore), writes ioctl bytes into the same RAM.
- Sits between hps_io and the RAM's second port; pauses the game CPU for the whole session.

---
 rtl/bombjack_pkg.sv | 15 +
 rtl/nv_lat_pipe.sv | 33 +++
 rtl/nvram_ioctl_bridge.sv | 187 ++++++++++++++++++
 tb/tb_nvram_ioctl_bridge.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bombjack_pkg.sv
// Shared types and constants for the NVRAM save/restore bridge.
package bombjack_pkg;

  localparam int         IOCTL_AW         = 25;
  localparam logic [7:0] NV_INDEX_DEFAULT = 8'd4;

  typedef enum logic [2:0] {
    NV_IDLE   = 3'd0,
    NV_PAUSE  = 3'd1,
    NV_READY  = 3'd2,
    NV_READ   = 3'd3,
    NV_WRBACK = 3'd4
  } nv_state_t;

endpackage

// File: rtl/nv_lat_pipe.sv
// Valid shift register: a start pulse emerges as done LAT cycles later,
// marking the cycle in which the RAM read data is to be captured.
module nv_lat_pipe #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic start,
  output logic done
);

  logic [LAT-1:0] vld_q, vld_d;

  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = start;
    if (flush) begin
      vld_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  assign done = vld_q[LAT-1];

endmodule

// File: rtl/nvram_ioctl_bridge.sv
// Bridges the hps_io ioctl channel to RAM port B for NVRAM save (upload) and restore (download).
// ram_q is captured RAM_LAT cycles after the edge that launches ram_rd, so an upload byte waits RAM_LAT+1 cycles.
module nvram_ioctl_bridge
  import bombjack_pkg::*;
#(
  parameter int         ADDR_W   = 10,
  parameter int         RAM_LAT  = 1,
  parameter logic [7:0] NV_INDEX = NV_INDEX_DEFAULT
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic [7:0]          ioctl_index,
  input  logic                ioctl_upload,
  input  logic                ioctl_download,
  input  logic                ioctl_rd,
  input  logic                ioctl_wr,
  input  logic [IOCTL_AW-1:0] ioctl_addr,
  input  logic [7:0]          ioctl_dout,
  output logic [7:0]          ioctl_din,
  output logic                ioctl_wait,
  output logic                pause_req,
  input  logic                pause_ack,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_rd,
  output logic                ram_wr,
  output logic [7:0]          ram_din,
  input  logic [7:0]          ram_q,
  output nv_state_t           state_dbg
);

  nv_state_t           state_q, state_d;
  logic                pause_req_q, pause_req_d;
  logic [7:0]          din_q, din_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic                ram_rd_q, ram_rd_d;
  logic                ram_wr_q, ram_wr_d;
  logic [7:0]          ram_din_q, ram_din_d;
  logic                oor_q, oor_d;
  logic                pend_q, pend_d;
  logic                pend_wr_q, pend_wr_d;
  logic [IOCTL_AW-1:0] pend_addr_q, pend_addr_d;
  logic [7:0]          pend_data_q, pend_data_d;

  logic                session;
  logic                rd_stb;
  logic                wr_stb;
  logic                go;
  logic                op_wr;
  logic [IOCTL_AW-1:0] op_addr;
  logic [7:0]          op_data;
  logic                op_in_range;
  logic                lat_start;
  logic                lat_flush;
  logic                lat_done;

  // Download wins when both session flags are high, so rd only counts in a pure upload.
  assign session     = (ioctl_upload | ioctl_download) && (ioctl_index == NV_INDEX);
  assign rd_stb      = ioctl_rd & ioctl_upload & ~ioctl_download;
  assign wr_stb      = ioctl_wr & ioctl_download;
  assign go          = pend_q | rd_stb | wr_stb;
  assign op_wr       = pend_q ? pend_wr_q   : wr_stb;
  assign op_addr     = pend_q ? pend_addr_q : ioctl_addr;
  assign op_data     = pend_q ? pend_data_q : ioctl_dout;
  assign op_in_range = (op_addr >> ADDR_W) == '0;
  assign lat_flush   = ~session;

  nv_lat_pipe #(.LAT(RAM_LAT)) u_lat_pipe (
    .clk   (clk_sys),
    .rst   (reset),
    .flush (lat_flush),
    .start (lat_start),
    .done  (lat_done)
  );

  always_comb begin
    state_d     = state_q;
    pause_req_d = pause_req_q;
    din_d       = din_q;
    ram_addr_d  = ram_addr_q;
    ram_rd_d    = 1'b0;
    ram_wr_d    = 1'b0;
    ram_din_d   = ram_din_q;
    oor_d       = oor_q;
    pend_d      = pend_q;
    pend_wr_d   = pend_wr_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    lat_start   = 1'b0;

    if (!session) begin
      // Session end abandons any operation; ioctl_din deliberately keeps its last byte.
      state_d     = NV_IDLE;
      pause_req_d = 1'b0;
      pend_d      = 1'b0;
      ram_addr_d  = '0;
      ram_din_d   = '0;
      oor_d       = 1'b0;
    end else begin
      case (state_q)
        NV_IDLE: begin
          state_d     = NV_PAUSE;
          pause_req_d = 1'b1;
        end
        NV_PAUSE: begin
          if (rd_stb | wr_stb) begin
            pend_d      = 1'b1;
            pend_wr_d   = wr_stb;
            pend_addr_d = ioctl_addr;
            pend_data_d = ioctl_dout;
          end
          if (pause_ack) begin
            state_d = NV_READY;
          end
        end
        NV_READY: begin
          if (go) begin
            pend_d     = 1'b0;
            ram_addr_d = op_addr[ADDR_W-1:0];
            oor_d      = ~op_in_range;
            if (op_wr) begin
              state_d   = NV_WRBACK;
              ram_wr_d  = op_in_range;
              ram_din_d = op_data;
            end else begin
              state_d   = NV_READ;
              ram_rd_d  = op_in_range;
              lat_start = 1'b1;
            end
          end
        end
        NV_READ: begin
          if (lat_done) begin
            din_d   = oor_q ? 8'h00 : ram_q;
            state_d = NV_READY;
          end
        end
        NV_WRBACK: begin
          state_d = NV_READY;
        end
        default: begin
          state_d = NV_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= NV_IDLE;
      pause_req_q <= 1'b0;
      din_q       <= '0;
      ram_addr_q  <= '0;
      ram_rd_q    <= 1'b0;
      ram_wr_q    <= 1'b0;
      ram_din_q   <= '0;
      oor_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_wr_q   <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
    end else begin
      state_q     <= state_d;
      pause_req_q <= pause_req_d;
      din_q       <= din_d;
      ram_addr_q  <= ram_addr_d;
      ram_rd_q    <= ram_rd_d;
      ram_wr_q    <= ram_wr_d;
      ram_din_q   <= ram_din_d;
      oor_q       <= oor_d;
      pend_q      <= pend_d;
      pend_wr_q   <= pend_wr_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
    end
  end

  // Combinational so the strobe cycle itself reports wait; held low while reset is asserted.
  assign ioctl_wait = ~reset & session & ((state_q != NV_READY) | go);
  assign ioctl_din  = din_q;
  assign pause_req  = pause_req_q;
  assign ram_addr   = ram_addr_q;
  assign ram_rd     = ram_rd_q;
  assign ram_wr     = ram_wr_q;
  assign ram_din    = ram_din_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_nvram_ioctl_bridge.sv
// Bench for nvram_ioctl_bridge: RAM_LAT=1 and RAM_LAT=3 instances share one host, each with its own RAM model.
`timescale 1ns/1ps
module tb_nvram_ioctl_bridge;
  import bombjack_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  // clock / reset
  logic clk_sys = 1'b0;
  logic reset;
  always #5 clk_sys = ~clk_sys;

  logic [7:0]  ioctl_index;
  logic        ioctl_upload, ioctl_download, ioctl_rd, ioctl_wr, pause_ack;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;

  logic [7:0]        din1, din3, rdin1, rdin3, ram_q1, ram_q3;
  logic              wait1, wait3, preq1, preq3, rrd1, rrd3, rwr1, rwr3;
  logic [ADDR_W-1:0] raddr1, raddr3;
  nv_state_t         st1, st3;

  nvram_ioctl_bridge #(.ADDR_W(ADDR_W), .RAM_LAT(1), .NV_INDEX(8'd4)) dut1 (
    .clk_sys(clk_sys), .reset(reset), .ioctl_index(ioctl_index), .ioctl_upload(ioctl_upload),
    .ioctl_download(ioctl_download), .ioctl_rd(ioctl_rd), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_din(din1), .ioctl_wait(wait1), .pause_req(preq1), .pause_ack(pause_ack),
    .ram_addr(raddr1), .ram_rd(rrd1), .ram_wr(rwr1), .ram_din(rdin1), .ram_q(ram_q1), .state_dbg(st1)
  );

  nvram_ioctl_bridge #(.ADDR_W(ADDR_W), .RAM_LAT(3), .NV_INDEX(8'd4)) dut3 (
    .clk_sys(clk_sys), .reset(reset), .ioctl_index(ioctl_index), .ioctl_upload(ioctl_upload),
    .ioctl_download(ioctl_download), .ioctl_rd(ioctl_rd), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_din(din3), .ioctl_wait(wait3), .pause_req(preq3), .pause_ack(pause_ack),
    .ram_addr(raddr3), .ram_rd(rrd3), .ram_wr(rwr3), .ram_din(rdin3), .ram_q(ram_q3), .state_dbg(st3)
  );

  // reference memory contents and per-instance RAM models
  logic [7:0]        ref_mem [DEPTH];
  logic [7:0]        mem1 [DEPTH];
  logic [7:0]        mem3 [DEPTH];
  logic              preload;
  logic              h3_v [2];
  logic [ADDR_W-1:0] h3_a [2];

  always @(posedge clk_sys) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem1[i] <= ref_mem[i];
        mem3[i] <= ref_mem[i];
      end
    end else begin
      if (rwr1) mem1[raddr1] <= rdin1;
      if (rwr3) mem3[raddr3] <= rdin3;
    end
    h3_v[0] <= rrd3 & ~reset;
    h3_v[1] <= h3_v[0] & ~reset;
    h3_a[0] <= raddr3;
    h3_a[1] <= h3_a[0];
  end

  // Data only appears when a read was actually launched; otherwise a poison byte.
  always_comb begin
    ram_q1 = rrd1 ? mem1[raddr1] : 8'hEE;
    ram_q3 = h3_v[1] ? mem3[h3_a[1]] : 8'hEE;
  end

  // scoreboard
  int checks = 0;
  int failures = 0;
  int rd_cnt1 = 0, rd_cnt3 = 0;
  logic [ADDR_W-1:0] rd_last1, rd_last3;
  logic [17:0] exp_w1_q[$];
  logic [17:0] exp_w3_q[$];
  logic [7:0]  last_din_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk_sys) begin
    if (rrd1) begin rd_cnt1++; rd_last1 = raddr1; end
    if (rrd3) begin rd_cnt3++; rd_last3 = raddr3; end
    if (rwr1) begin
      if (exp_w1_q.size() == 0) check("wr1_unexpected", {14'd0, raddr1, rdin1}, 32'hFFFF_FFFF);
      else check("wr1_data", {raddr1, rdin1}, exp_w1_q.pop_front());
    end
    if (rwr3) begin
      if (exp_w3_q.size() == 0) check("wr3_unexpected", {14'd0, raddr3, rdin3}, 32'hFFFF_FFFF);
      else check("wr3_data", {raddr3, rdin3}, exp_w3_q.pop_front());
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_both(output int n1, output int n3);
    n1 = 0;
    n3 = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_sys);
      if (wait1) n1++;
      if (wait3) n3++;
      if (!wait1 && !wait3) begin
        ioctl_rd = 1'b0;
        ioctl_wr = 1'b0;
        return;
      end
      tick();
      ioctl_rd = 1'b0;
      ioctl_wr = 1'b0;
    end
    check("wait_timeout", 1, 0);
  endtask

  task automatic open_session(input logic [7:0] idx, input logic up, input logic dn, input int ack_dly);
    int ok;
    tick();
    ioctl_index = idx; ioctl_upload = up; ioctl_download = dn;
    ok = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_sys);
      if (preq1 && preq3) begin ok = 1; break; end
    end
    check("preq_rise", ok, 1);
    repeat (ack_dly) tick();
    pause_ack = 1'b1;
  endtask

  task automatic close_session();
    tick();
    ioctl_upload = 1'b0; ioctl_download = 1'b0; pause_ack = 1'b0;
    @(negedge clk_sys);
    check("end_wait", {wait1, wait3}, 0);
    check("end_preq_hold", {preq1, preq3}, 2'b11);
    @(negedge clk_sys);
    check("end_preq_clear", {preq1, preq3}, 0);
    check("end_state1", st1, NV_IDLE);
    check("end_state3", st3, NV_IDLE);
  endtask

  task automatic do_txn(input logic wr, input logic [24:0] a, input logic [7:0] d, input logic [7:0] exp_din);
    int n1, n3, c1, c3, inr;
    inr = (a < 25'(DEPTH)) ? 1 : 0;
    c1 = rd_cnt1;
    c3 = rd_cnt3;
    if (wr && inr == 1) begin
      exp_w1_q.push_back({a[ADDR_W-1:0], d});
      exp_w3_q.push_back({a[ADDR_W-1:0], d});
      ref_mem[a[ADDR_W-1:0]] = d;
    end
    tick();
    ioctl_addr = a; ioctl_dout = d; ioctl_rd = ~wr; ioctl_wr = wr;
    wait_both(n1, n3);
    if (wr) begin
      check("wr_wait1", n1, 2);
      check("wr_wait3", n3, 2);
      check("wr_done1", exp_w1_q.size(), 0);
      check("wr_done3", exp_w3_q.size(), 0);
      check("wr_din_hold1", din1, last_din_exp);
      check("wr_no_rd1", rd_cnt1 - c1, 0);
      check("wr_no_rd3", rd_cnt3 - c3, 0);
    end else begin
      check("rd_wait1", n1, 2);
      check("rd_wait3", n3, 4);
      check("rd_din1", din1, exp_din);
      check("rd_din3", din3, exp_din);
      check("rd_pulses1", rd_cnt1 - c1, inr);
      check("rd_pulses3", rd_cnt3 - c3, inr);
      if (inr == 1) begin
        check("rd_addr1", rd_last1, a[ADDR_W-1:0]);
        check("rd_addr3", rd_last3, a[ADDR_W-1:0]);
      end
      last_din_exp = exp_din;
    end
  endtask

  function automatic logic [24:0] rand_addr();
    logic [24:0] a;
    if ($urandom_range(0, 7) == 0) a = 25'($urandom_range(DEPTH, 32'h1FF_FFFF));
    else a = 25'($urandom_range(0, DEPTH - 1));
    return a;
  endfunction

  typedef struct {
    logic        wr;
    logic [24:0] addr;
    logic [7:0]  data;
    logic [7:0]  exp_din;
  } vec_t;
  vec_t vecs [10];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int c1, c3, n1, n3;
    logic [24:0] a;
    logic [7:0]  d;
    logic [7:0]  keep;

    vecs[0] = '{1'b1, 25'h000_0000, 8'h11, 8'h00};
    vecs[1] = '{1'b1, 25'h000_0001, 8'h22, 8'h00};
    vecs[2] = '{1'b1, 25'h000_0002, 8'h33, 8'h00};
    vecs[3] = '{1'b1, 25'h1FF_FFFF, 8'h44, 8'h00};
    vecs[4] = '{1'b0, 25'h000_0000, 8'h00, 8'h11};
    vecs[5] = '{1'b0, 25'h000_0002, 8'h00, 8'h33};
    vecs[6] = '{1'b0, 25'h000_0001, 8'h00, 8'h22};
    vecs[7] = '{1'b0, 25'h000_0400, 8'h00, 8'h00};
    vecs[8] = '{1'b0, 25'h000_03FF, 8'h00, 8'h5C};
    vecs[9] = '{1'b0, 25'h1FF_FFFF, 8'h00, 8'h00};

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'($urandom);
    ref_mem[5]     = 8'hA5;
    ref_mem[10'h3FF] = 8'h5C;
    last_din_exp = 8'h00;

    reset = 1'b1; preload = 1'b1;
    ioctl_index = 8'd0; ioctl_upload = 1'b0; ioctl_download = 1'b0;
    ioctl_rd = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0; pause_ack = 1'b0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check("reset_out1", {din1, wait1, preq1, raddr1, rrd1, rwr1, rdin1}, 0);
    check("reset_out3", {din3, wait3, preq3, raddr3, rrd3, rwr3, rdin3}, 0);
    check("reset_state", {st1, st3}, {NV_IDLE, NV_IDLE});
    reset = 1'b0; preload = 1'b0;
    @(negedge clk_sys);
    check("idle_out1", {din1, wait1, preq1, rrd1, rwr1}, 0);

    // Upload with the read strobe issued during PAUSE; ack lands 3 cycles after pause_req.
    tick();
    ioctl_index = 8'd4; ioctl_upload = 1'b1;
    @(negedge clk_sys);
    check("idle_wait", {wait1, wait3}, 2'b11);
    tick();
    @(negedge clk_sys);
    check("pause_state", st1, NV_PAUSE);
    check("pause_req", {preq1, preq3}, 2'b11);
    c1 = rd_cnt1; c3 = rd_cnt3;
    tick();
    ioctl_addr = 25'h5; ioctl_rd = 1'b1;
    @(negedge clk_sys);
    check("pause_stb_wait", {wait1, wait3}, 2'b11);
    tick();
    ioctl_rd = 1'b0;
    tick();
    pause_ack = 1'b1;
    wait_both(n1, n3);
    check("pause_rd_wait1", n1, 3);
    check("pause_rd_wait3", n3, 5);
    check("pause_rd_din1", din1, 8'hA5);
    check("pause_rd_din3", din3, 8'hA5);
    check("pause_rd_pulse1", rd_cnt1 - c1, 1);
    check("pause_rd_pulse3", rd_cnt3 - c3, 1);
    check("pause_rd_addr1", rd_last1, 10'h5);
    last_din_exp = 8'hA5;
    close_session();

    // Table vectors: download (both session flags high, download wins), then upload.
    open_session(8'd4, 1'b1, 1'b1, 2);
    for (int i = 0; i < 4; i++) do_txn(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp_din);
    close_session();
    open_session(8'd4, 1'b1, 1'b0, 0);
    for (int i = 4; i < 10; i++) do_txn(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp_din);
    close_session();

    // Foreign index: the bridge must stay completely quiet.
    c1 = rd_cnt1;
    tick();
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    for (int k = 0; k < 12; k++) begin
      ioctl_addr = 25'(k); ioctl_dout = 8'(k + 8'h70); ioctl_wr = k[0];
      @(negedge clk_sys);
      check("rom_quiet1", {preq1, wait1, rwr1}, 0);
      check("rom_quiet3", {preq3, wait3, rwr3}, 0);
      tick();
    end
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    check("rom_state", {st1, st3}, {NV_IDLE, NV_IDLE});
    check("rom_no_rd", rd_cnt1 - c1, 0);

    // Randomized download then upload against the reference memory.
    open_session(8'd4, 1'b0, 1'b1, $urandom_range(0, 3));
    for (int k = 0; k < 30; k++) begin
      a = rand_addr();
      d = 8'($urandom);
      do_txn(1'b1, a, d, 8'h00);
    end
    close_session();
    open_session(8'd4, 1'b1, 1'b0, $urandom_range(0, 3));
    for (int k = 0; k < 30; k++) begin
      a = rand_addr();
      do_txn(1'b0, a, 8'h00, (a < 25'(DEPTH)) ? ref_mem[a[ADDR_W-1:0]] : 8'h00);
    end

    // Session dropped one cycle after a read strobe: read abandoned.
    keep = last_din_exp;
    tick();
    ioctl_addr = 25'h9; ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0; ioctl_upload = 1'b0; pause_ack = 1'b0;
    @(negedge clk_sys);
    check("abort_wait", {wait1, wait3}, 0);
    @(negedge clk_sys);
    check("abort_state3", st3, NV_IDLE);
    check("abort_state1", st1, NV_IDLE);
    check("abort_preq", {preq1, preq3}, 0);
    check("abort_din3", din3, keep);
    check("abort_din1", din1, keep);
    repeat (4) tick();
    @(negedge clk_sys);
    check("abort_din3_late", din3, keep);

    // Asynchronous reset between clock edges in the middle of a read.
    open_session(8'd4, 1'b1, 1'b0, 1);
    do_txn(1'b0, 25'h7, 8'h00, ref_mem[7]);
    tick();
    ioctl_addr = 25'h3; ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    #2;
    check("pre_reset_busy", {wait1, wait3}, 2'b11);
    reset = 1'b1;
    #1;
    check("async_out1", {din1, wait1, preq1, raddr1, rrd1, rwr1, rdin1}, 0);
    check("async_out3", {din3, wait3, preq3, raddr3, rrd3, rwr3, rdin3}, 0);
    check("async_state", {st1, st3}, {NV_IDLE, NV_IDLE});
    pause_ack = 1'b0;
    @(negedge clk_sys);
    reset = 1'b0;
    last_din_exp = 8'h00;
    @(negedge clk_sys);
    check("restart_state", {st1, st3}, {NV_PAUSE, NV_PAUSE});
    check("restart_preq", {preq1, preq3}, 2'b11);
    tick();
    pause_ack = 1'b1;
    do_txn(1'b0, 25'h3, 8'h00, ref_mem[3]);
    close_session();

    check("wr_queue1_empty", exp_w1_q.size(), 0);
    check("wr_queue3_empty", exp_w3_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
